// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-N-1 UART receiver with internal 16x oversample tick
module uart_rx #(
  parameter int CLK_DIV = 27
) (
  input  logic       clk50m,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

  logic       r_sync1;
  logic       r_sync2;
  state_t     r_state;
  logic [7:0] r_tcnt;
  logic [3:0] r_scnt;
  logic [2:0] r_bidx;
  logic [7:0] r_sh;
  logic [7:0] r_rxdata;
  logic       r_rxvalid;
  logic       r_frame_err;
  logic       r_busy;

  logic       w_rxd_s;
  logic       w_tick;

  assign w_rxd_s   = r_sync2;
  assign w_tick    = (r_tcnt == TICK_LAST);

  assign rxdata    = r_rxdata;
  assign rxvalid   = r_rxvalid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM with tick/sample counters, shift register and registered outputs.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_tcnt      <= 8'd0;
      r_scnt      <= 4'd0;
      r_bidx      <= 3'd0;
      r_sh        <= 8'd0;
      r_rxdata    <= 8'h00;
      r_rxvalid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rxvalid   <= 1'b0;
      r_frame_err <= 1'b0;
      // busy follows the state one cycle later
      r_busy      <= (r_state != S_IDLE);

      // tick divider free-runs; restarted when a start edge is seen
      if (w_tick) begin
        r_tcnt <= 8'd0;
        r_scnt <= r_scnt + 4'd1;
      end else begin
        r_tcnt <= r_tcnt + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxd_s) begin
            r_tcnt  <= 8'd0;
            r_scnt  <= 4'd0;
            r_state <= S_START;
          end
        end

        S_START: begin
          // mid start bit: a high line here means the low was a glitch
          if (w_tick && (r_scnt == 4'd7)) begin
            if (w_rxd_s) begin
              r_state <= S_IDLE;
            end else begin
              r_scnt  <= 4'd0;
              r_bidx  <= 3'd0;
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          // mid data bit: shift in at the MSB so the byte ends up LSB-first
          if (w_tick && (r_scnt == 4'd15)) begin
            r_sh   <= {w_rxd_s, r_sh[7:1]};
            r_bidx <= r_bidx + 3'd1;
            if (r_bidx == 3'd7) begin
              r_state <= S_STOP;
            end
          end
        end

        S_STOP: begin
          // mid stop bit: back to IDLE here so a back-to-back start is caught
          if (w_tick && (r_scnt == 4'd15)) begin
            if (w_rxd_s) begin
              r_rxdata  <= r_sh;
              r_rxvalid <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end
        end

        S_WAIT_HIGH: begin
          // a held-low (break) line must not retrigger frames
          if (w_rxd_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CLK_DIV = 4;
  localparam int BIT_CYC = 16 * CLK_DIV;

  logic       clk50m  = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd     = 1'b1;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .clk50m    (clk50m),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .rxdata    (rxdata),
    .rxvalid   (rxvalid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk50m = ~clk50m;

  int cyc = 0;
  always @(posedge clk50m) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  // event encoding: good byte = byte value, framing error = 256 + rxdata at that moment
  int exp_q[$];
  int got_q[$];
  int got_cyc[$];
  int last_good = 0;
  int overlap = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk50m) begin
    if (reset_n) begin
      if (rxvalid && frame_err) overlap++;
      if (rxvalid) begin
        got_q.push_back(int'(rxdata));
        got_cyc.push_back(cyc);
      end
      if (frame_err) begin
        got_q.push_back(256 + int'(rxdata));
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  // Reference: a frame with a good stop yields its byte; a bad stop yields an
  // error event while rxdata still shows the last good byte.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input int bc);
    hold(1'b0, bc);
    for (int i = 0; i < 8; i++) hold(d[i], bc);
    hold(stopv, bc);
    if (stopv) begin
      exp_q.push_back(int'(d));
      last_good = int'(d);
    end else begin
      exp_q.push_back(256 + last_good);
    end
  endtask

  task automatic compare(input string name);
    int n;
    chk({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int t_fall;
    int diff;
    logic [7:0] d;
    int bc;
    logic stopv;

    #2;
    chk("reset_rxdata", rxdata, 8'h00);
    chk("reset_rxvalid", rxvalid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    repeat (3) @(posedge clk50m);
    #1;
    reset_n = 1'b1;
    hold(1'b1, 10);

    // single byte with latency check
    t_fall = cyc;
    send_frame(8'hA5, 1'b1, BIT_CYC);
    hold(1'b1, 40);
    if (got_cyc.size() > 0) begin
      diff = got_cyc[0] - t_fall;
      chk("latency_612pm2", (diff >= 610 && diff <= 614), 1'b1);
    end else begin
      chk("latency_pulse_seen", 1'b0, 1'b1);
    end
    compare("single");

    // back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, BIT_CYC);
    send_frame(8'hFF, 1'b1, BIT_CYC);
    send_frame(8'h3C, 1'b1, BIT_CYC);
    hold(1'b1, 40);
    compare("b2b");

    // glitch of 4 ticks must be ignored
    hold(1'b0, 4 * CLK_DIV);
    hold(1'b1, 50);
    chk("glitch_busy", busy, 1'b0);
    compare("glitch");
    send_frame(8'h5A, 1'b1, BIT_CYC);
    hold(1'b1, 40);
    compare("after_glitch");

    // framing error followed by a long break
    send_frame(8'h81, 1'b0, BIT_CYC);
    hold(1'b0, 30 * BIT_CYC);
    chk("break_busy", busy, 1'b1);
    hold(1'b1, 40);
    compare("break");
    send_frame(8'h42, 1'b1, BIT_CYC);
    hold(1'b1, 40);
    compare("after_break");

    // reset during data bit 3 of 0xC3
    hold(1'b0, BIT_CYC);
    hold(1'b1, BIT_CYC);
    hold(1'b1, BIT_CYC);
    hold(1'b0, BIT_CYC);
    hold(1'b0, BIT_CYC / 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_rxdata", rxdata, 8'h00);
    chk("midreset_rxvalid", rxvalid, 1'b0);
    chk("midreset_frame_err", frame_err, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    rxd = 1'b1;
    last_good = 0;
    repeat (3) @(posedge clk50m);
    #1;
    reset_n = 1'b1;
    hold(1'b1, 20);
    send_frame(8'h99, 1'b1, BIT_CYC);
    hold(1'b1, 40);
    compare("reset");

    // baud skew of about +-3%
    send_frame(8'h6E, 1'b1, 62);
    hold(1'b1, 40);
    send_frame(8'h6E, 1'b1, 66);
    hold(1'b1, 40);
    compare("skew");

    // randomized traffic
    for (int k = 0; k < 24; k++) begin
      d     = 8'($urandom_range(0, 255));
      bc    = int'($urandom_range(62, 66));
      stopv = ($urandom_range(0, 9) != 0);
      send_frame(d, stopv, bc);
      if (stopv) hold(1'b1, int'($urandom_range(0, 30)));
      else       hold(1'b1, 2 * bc + int'($urandom_range(0, 20)));
    end
    hold(1'b1, 60);
    compare("random");

    chk("pulse_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
